// File: rtl/inst_loader.sv
// Collects three host words into one packed instruction and writes it to instruction memory.
// Optional INST_LOADER_CHECKSUM_EN adds checksum_out, the XOR of every written word.
module inst_loader #(
  parameter int unsigned          AXI4L_DATA_WIDTH = 32,
  parameter int unsigned          CMD_WIDTH        = 8,
  parameter logic [CMD_WIDTH-1:0] CMD_END          = CMD_WIDTH'(3)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [AXI4L_DATA_WIDTH-1:0]   word_in,
  input  logic                          word_valid_in,
  output logic                          word_ready_out,
  input  logic                          restart_in,
  output logic [3*AXI4L_DATA_WIDTH-1:0] inst_out,
  output logic [AXI4L_DATA_WIDTH-1:0]   inst_addr_out,
  output logic                          inst_wr_en_out,
  output logic [11:0]                   inst_count_out,
  output logic                          loaded_out,
  output logic                          error_out,
`ifdef INST_LOADER_CHECKSUM_EN
  output logic [AXI4L_DATA_WIDTH-1:0]   checksum_out,
`endif
  output logic [3:0]                    state_vec_out
);

  localparam int unsigned W = AXI4L_DATA_WIDTH;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StWrite   = 3'd2,
    StLoaded  = 3'd3,
    StError   = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [10:0]    addr_q, addr_d;
  logic [11:0]    count_q, count_d;
  logic           loaded_q, loaded_d;
  logic           error_q, error_d;
  logic [3*W-1:0] inst_q, inst_d;
  logic           accept;
  logic           wr_en;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    error_d  = error_q;
    inst_d   = inst_q;

    word_ready_out = (state_q == StIdle) || (state_q == StCollect);
    accept         = word_valid_in && word_ready_out;
    // A coincident restart or reset cancels the pending write strobe.
    wr_en          = (state_q == StWrite) && !restart_in && !reset;

    if (restart_in) begin
      state_d  = StIdle;
      idx_d    = 2'd0;
      addr_d   = 11'd0;
      count_d  = 12'd0;
      loaded_d = 1'b0;
      error_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StCollect: begin
          if (accept) begin
            case (idx_q)
              2'd0:    inst_d[W-1:0]     = word_in;
              2'd1:    inst_d[2*W-1:W]   = word_in;
              default: inst_d[3*W-1:2*W] = word_in;
            endcase
            if (idx_q == 2'd2) begin
              idx_d   = 2'd0;
              state_d = StWrite;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = StCollect;
            end
          end
        end
        StWrite: begin
          addr_d  = addr_q + 11'd1;
          count_d = (count_q == 12'd2048) ? count_q : count_q + 12'd1;
          if (inst_q[CMD_WIDTH-1:0] == CMD_END) begin
            loaded_d = 1'b1;
            state_d  = StLoaded;
          end else if (addr_q == 11'h7FF) begin
            error_d = 1'b1;
            state_d = StError;
          end else begin
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= 2'd0;
      addr_q   <= 11'd0;
      count_q  <= 12'd0;
      loaded_q <= 1'b0;
      error_q  <= 1'b0;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
      error_q  <= error_d;
      inst_q   <= inst_d;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (restart_in) begin
      checksum_d = '0;
    end else if (wr_en) begin
      checksum_d = checksum_q ^ inst_q[W-1:0] ^ inst_q[2*W-1:W] ^ inst_q[3*W-1:2*W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum_out = checksum_q;
`endif

  assign inst_out       = inst_q;
  assign inst_addr_out  = {{(W-11){1'b0}}, addr_q};
  assign inst_wr_en_out = wr_en;
  assign inst_count_out = count_q;
  assign loaded_out     = loaded_q;
  assign error_out      = error_q;
  assign state_vec_out  = {1'b0, state_q};

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: expected writes are queued when stimulus is driven
// and popped on every observed write strobe.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] word_in;
  logic        word_valid_in;
  logic        word_ready_out;
  logic        restart_in;
  logic [95:0] inst_out;
  logic [31:0] inst_addr_out;
  logic        inst_wr_en_out;
  logic [11:0] inst_count_out;
  logic        loaded_out;
  logic        error_out;
  logic [3:0]  state_vec_out;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0] checksum_out;
`endif

  inst_loader dut (
    .clk           (clk),
    .reset         (reset),
    .word_in       (word_in),
    .word_valid_in (word_valid_in),
    .word_ready_out(word_ready_out),
    .restart_in    (restart_in),
    .inst_out      (inst_out),
    .inst_addr_out (inst_addr_out),
    .inst_wr_en_out(inst_wr_en_out),
    .inst_count_out(inst_count_out),
    .loaded_out    (loaded_out),
    .error_out     (error_out),
`ifdef INST_LOADER_CHECKSUM_EN
    .checksum_out  (checksum_out),
`endif
    .state_vec_out (state_vec_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [95:0] inst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_strobes = 0;
  int   exp_addr = 0;
  bit   last_acc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One clock cycle: sample at the falling edge, return 1ns after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_acc = word_valid_in && word_ready_out;
    if (inst_wr_en_out === 1'b1) begin
      n_strobes++;
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 128'(inst_wr_en_out), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 128'(inst_addr_out), 128'(e.addr));
        chk("wr_inst", 128'(inst_out), 128'(e.inst));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    bit ok = 1'b0;
    word_in       = w;
    word_valid_in = 1'b1;
    for (int i = 0; i < 16 && !ok; i++) begin
      cycle();
      ok = last_acc;
    end
    if (!ok) chk("accept_timeout", 128'(ok), 128'(1));
    word_valid_in = 1'b0;
    word_in       = '0;
    if (gap) cycle();
  endtask

  // Sends a full instruction and runs its write cycle.
  task automatic send_instr(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input bit gap);
    send_word(w0, gap);
    send_word(w1, gap);
    sb.push_back('{addr: 32'(exp_addr), inst: {w2, w1, w0}});
    exp_addr++;
    send_word(w2, 1'b0);
    cycle();
  endtask

  task automatic do_restart();
    restart_in = 1'b1;
    cycle();
    restart_in = 1'b0;
    exp_addr   = 0;
  endtask

  int saved;

  initial begin
    reset = 1'b1; word_in = '0; word_valid_in = 1'b0; restart_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_inst", 128'(inst_out), 128'(0));
    chk("rst_addr", 128'(inst_addr_out), 128'(0));
    chk("rst_wr_en", 128'(inst_wr_en_out), 128'(0));
    chk("rst_count", 128'(inst_count_out), 128'(0));
    chk("rst_flags", 128'({loaded_out, error_out}), 128'(0));
    chk("rst_state", 128'(state_vec_out), 128'(0));
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 128'(word_ready_out), 128'(1));

    // Single END instruction.
    send_instr(32'h0000_0003, 32'h0, 32'h0, 1'b0);
    chk("end_loaded", 128'(loaded_out), 128'(1));
    chk("end_ready", 128'(word_ready_out), 128'(0));
    chk("end_count", 128'(inst_count_out), 128'(1));
    chk("end_state", 128'(state_vec_out), 128'(3));
    chk("end_sb_empty", 128'(sb.size()), 128'(0));
    do_restart();
    chk("rst1_state", 128'(state_vec_out), 128'(0));
    chk("rst1_count", 128'(inst_count_out), 128'(0));
    chk("rst1_loaded", 128'(loaded_out), 128'(0));
    chk("rst1_ready", 128'(word_ready_out), 128'(1));

    // Five plain instructions then END, valid toggling every other cycle.
    for (int i = 0; i < 5; i++)
      send_instr({24'(i), 8'h10}, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1'b1);
    send_instr(32'hABCD_0003, 32'h1111_1111, 32'h2222_2222, 1'b1);
    chk("seq_count", 128'(inst_count_out), 128'(6));
    chk("seq_loaded", 128'(loaded_out), 128'(1));
    chk("seq_sb_empty", 128'(sb.size()), 128'(0));

    // Restart coincident with word 2 acceptance discards the instruction.
    do_restart();
    send_word(32'h0000_0021, 1'b0);
    send_word(32'h0000_0022, 1'b0);
    word_in = 32'h0000_0023; word_valid_in = 1'b1; restart_in = 1'b1;
    cycle();
    word_valid_in = 1'b0; restart_in = 1'b0; exp_addr = 0;
    cycle();
    cycle();
    chk("rsw_state", 128'(state_vec_out), 128'(0));
    chk("rsw_count", 128'(inst_count_out), 128'(0));
    send_instr(32'h0000_0031, 32'h32, 32'h33, 1'b0);
    chk("rsw_count_after", 128'(inst_count_out), 128'(1));

    // Reset after two words of the next instruction.
    send_word(32'h0000_0041, 1'b0);
    send_word(32'h0000_0042, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0; exp_addr = 0;
    chk("mid_inst", 128'(inst_out), 128'(0));
    chk("mid_addr", 128'(inst_addr_out), 128'(0));
    chk("mid_count", 128'(inst_count_out), 128'(0));
    chk("mid_state", 128'(state_vec_out), 128'(0));
    send_instr(32'h0000_0051, 32'h52, 32'h53, 1'b0);
    chk("mid_count_after", 128'(inst_count_out), 128'(1));

    // Reset during the write cycle suppresses the strobe.
    send_word(32'h0000_0061, 1'b0);
    send_word(32'h0000_0062, 1'b0);
    send_word(32'h0000_0063, 1'b0);
    reset = 1'b1;
    cycle();
    reset = 1'b0; exp_addr = 0;
    chk("wrst_count", 128'(inst_count_out), 128'(0));
    chk("wrst_state", 128'(state_vec_out), 128'(0));

`ifdef INST_LOADER_CHECKSUM_EN
    do_restart();
    send_instr(32'h1, 32'h2, 32'h4, 1'b0);
    send_instr(32'h3, 32'h0, 32'h0, 1'b0);
    chk("checksum", 128'(checksum_out), 128'(32'h4));
    do_restart();
    chk("checksum_clear", 128'(checksum_out), 128'(0));
`endif

    // Fill all 2048 addresses with non-END instructions.
    do_restart();
    for (int i = 0; i < 2048; i++)
      send_instr({24'(i), 8'h11}, 32'(i) ^ 32'h5A5A_5A5A, ~32'(i), 1'b0);
    chk("ovf_error", 128'(error_out), 128'(1));
    chk("ovf_state", 128'(state_vec_out), 128'(4));
    chk("ovf_count", 128'(inst_count_out), 128'(2048));
    chk("ovf_ready", 128'(word_ready_out), 128'(0));
    chk("ovf_loaded", 128'(loaded_out), 128'(0));
    chk("ovf_sb_empty", 128'(sb.size()), 128'(0));
    saved = n_strobes;
    word_in = 32'h0000_0077; word_valid_in = 1'b1;
    repeat (10) cycle();
    word_valid_in = 1'b0;
    chk("ovf_no_extra", 128'(n_strobes), 128'(saved));
    chk("ovf_hold", 128'(state_vec_out), 128'(4));
    do_restart();
    chk("ovf_restart_state", 128'(state_vec_out), 128'(0));
    chk("ovf_restart_error", 128'(error_out), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
